// File: rtl/pdm_tone_player_if.sv
// pdm_tone_player_if
//   Control bundle between the logic controller (master) and the tone
//   player (slave).
//   start_i       : one-cycle burst request
//   half_period_i : tone half-period in PDM ticks
//   duration_i    : beep / gap length in PDM ticks
//   amplitude_i   : high-phase sample value
//   repeat_i      : number of beeps minus one
//   busy_o        : burst in progress
//   done_o        : one-cycle completion pulse
interface pdm_tone_player_if #(
    parameter int HALF_W = 12,
    parameter int DUR_W  = 20
);
    logic              start_i;
    logic [HALF_W-1:0] half_period_i;
    logic [DUR_W-1:0]  duration_i;
    logic [7:0]        amplitude_i;
    logic [1:0]        repeat_i;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, half_period_i, duration_i, amplitude_i, repeat_i,
        input  busy_o, done_o
    );

    modport slave (
        input  start_i, half_period_i, duration_i, amplitude_i, repeat_i,
        output busy_o, done_o
    );
endinterface

// File: rtl/pdm_tone_player.sv
// pdm_tone_player
//   Generates 1..4 square-wave tone bursts separated by equal-length gaps and
//   encodes them as a first-order sigma-delta PDM bitstream.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   ctl     : control bundle (start request, tone parameters, busy/done)
//   AUD_PWM : PDM bitstream (logic level)
//   AUD_SD  : amplifier enable
//   Build option: define PDM_TONE_SD_GATE_EN to power the amplifier only
//   while a burst is running (AUD_SD = busy delayed one cycle); otherwise
//   AUD_SD is held high from the first cycle after reset.
module pdm_tone_player #(
    parameter int PDM_DIV = 40,
    parameter int HALF_W  = 12,
    parameter int DUR_W   = 20
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pdm_tone_player_if.slave   ctl,
    output logic               AUD_PWM,
    output logic               AUD_SD
);
    localparam int DIV_W = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;

    // S_ABORT holds busy for one cycle on a zero-length request so that
    // done_o lands two cycles after acceptance.
    typedef enum logic [2:0] {S_IDLE, S_TONE, S_GAP, S_ABORT, S_DONE} state_t;

    state_t            state, state_next;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [HALF_W-1:0] half_r, half_cnt;
    logic [DUR_W-1:0]  dur_r, dur_cnt;
    logic [7:0]        amp_r;
    logic [1:0]        beeps_left;
    logic              phase;
    logic [7:0]        acc;       // low byte of the 9-bit accumulator; bit 8 is the PWM carry
    logic [7:0]        sample;
    logic [8:0]        acc_next;
    logic              latch, enter_tone, dur_last, half_last;

    assign tick      = (div_cnt == DIV_W'(PDM_DIV - 1));
    assign dur_last  = (dur_cnt == dur_r - DUR_W'(1));
    assign half_last = (half_cnt == half_r - HALF_W'(1));
    assign sample    = (state == S_TONE && phase) ? amp_r : '0;
    assign acc_next  = {1'b0, acc} + {1'b0, sample};

    assign ctl.busy_o = (state == S_TONE) || (state == S_GAP) || (state == S_ABORT);
    assign ctl.done_o = (state == S_DONE);

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        enter_tone = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctl.start_i) begin
                    latch = 1'b1;
                    // Inputs equal the values being latched this cycle.
                    if (ctl.duration_i == '0 || ctl.half_period_i == '0) begin
                        state_next = S_ABORT;
                    end else begin
                        state_next = S_TONE;
                        enter_tone = 1'b1;
                    end
                end
            end
            S_TONE: begin
                if (tick && dur_last) begin
                    state_next = (beeps_left == '0) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (tick && dur_last) begin
                    state_next = S_TONE;
                    enter_tone = 1'b1;
                end
            end
            S_ABORT: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            half_r     <= '0;
            dur_r      <= '0;
            amp_r      <= '0;
            beeps_left <= '0;
            dur_cnt    <= '0;
            half_cnt   <= '0;
            phase      <= 1'b0;
            acc        <= '0;
            AUD_PWM    <= 1'b0;
            AUD_SD     <= 1'b0;
        end else begin
            state   <= state_next;
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

            if (latch) begin
                half_r     <= ctl.half_period_i;
                dur_r      <= ctl.duration_i;
                amp_r      <= ctl.amplitude_i;
                beeps_left <= ctl.repeat_i;
            end

            if (enter_tone) begin
                dur_cnt  <= '0;
                half_cnt <= '0;
                phase    <= 1'b1;
            end else if (state == S_TONE && tick) begin
                if (dur_last) begin
                    dur_cnt    <= '0;
                    beeps_left <= beeps_left - 2'd1;
                end else begin
                    dur_cnt <= dur_cnt + DUR_W'(1);
                end
                if (half_last) begin
                    half_cnt <= '0;
                    phase    <= ~phase;
                end else begin
                    half_cnt <= half_cnt + HALF_W'(1);
                end
            end else if (state == S_GAP && tick) begin
                dur_cnt <= dur_cnt + DUR_W'(1);
            end

            // Leaving the burst clears the modulator, so the final tick
            // drives AUD_PWM low for the done cycle and idle.
            if (state_next != S_TONE && state_next != S_GAP) begin
                acc     <= '0;
                AUD_PWM <= 1'b0;
            end else if (tick) begin
                acc     <= acc_next[7:0];
                AUD_PWM <= acc_next[8];
            end

`ifdef PDM_TONE_SD_GATE_EN
            AUD_SD <= ctl.busy_o;
`else
            AUD_SD <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_pdm_tone_player.sv
module tb_pdm_tone_player;
    localparam int DIV = 4;
    localparam int HW  = 12;
    localparam int DW  = 20;

    logic clk;
    logic rst;
    logic aud_pwm;
    logic aud_sd;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned ecount;
    logic        prev_busy = 1'b0;

    pdm_tone_player_if #(.HALF_W(HW), .DUR_W(DW)) bus ();

    pdm_tone_player #(.PDM_DIV(DIV), .HALF_W(HW), .DUR_W(DW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .ctl     (bus.slave),
        .AUD_PWM (aud_pwm),
        .AUD_SD  (aud_sd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of clock edges since reset release; the divider ticks on every
    // DIV-th such edge.
    always @(posedge clk) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic eb, input logic ed, input logic ep);
        check("busy_o", 32'(bus.busy_o), 32'(eb));
        check("done_o", 32'(bus.done_o), 32'(ed));
        check("aud_pwm", 32'(aud_pwm), 32'(ep));
`ifdef PDM_TONE_SD_GATE_EN
        check("aud_sd", 32'(aud_sd), 32'(prev_busy));
`else
        check("aud_sd", 32'(aud_sd), 32'd1);
`endif
        prev_busy = eb;
    endtask

    task automatic scramble();
        bus.half_period_i = HW'($urandom);
        bus.duration_i    = DW'($urandom);
        bus.amplitude_i   = 8'($urandom);
        bus.repeat_i      = 2'($urandom);
    endtask

    // Runs one request and checks every cycle against a model that derives
    // each tick's bit from its position inside the burst.
    task automatic run_burst(input int h, input int d, input int a, input int r,
                             output int ones100, output int ones_all);
        int  total, k, cycles, budget, macc, p, smp;
        logic cur, finished;
        ones100  = 0;
        ones_all = 0;
        total    = (2 * r + 1) * d;
        @(negedge clk);
        bus.half_period_i = HW'(h);
        bus.duration_i    = DW'(d);
        bus.amplitude_i   = 8'(a);
        bus.repeat_i      = 2'(r);
        bus.start_i       = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        scramble();
        if (d == 0 || h == 0) begin
            check_outputs(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            check_outputs(1'b0, 1'b1, 1'b0);
        end else begin
            // A tick on the acceptance edge itself belongs to IDLE.
            k = 0;
            if (ecount % DIV == 0) check_outputs(1'b1, 1'b0, 1'b0);
            else                   check_outputs(1'b1, 1'b0, 1'b0);
            cur      = 1'b0;
            macc     = 0;
            cycles   = 0;
            finished = 1'b0;
            budget   = (total + 2) * DIV + 10;
            while (!finished && cycles < budget) begin
                @(negedge clk);
                cycles++;
                scramble();
                bus.start_i = (cycles == 5);
                if (ecount % DIV == 0) begin
                    k++;
                    if (k == total) begin
                        finished = 1'b1;
                    end else begin
                        p   = k - 1;
                        smp = 0;
                        if ((p / d) % 2 == 0 && ((p % d) / h) % 2 == 0) smp = a;
                        macc = (macc % 256) + smp;
                        cur  = (macc >= 256);
                        if (cur) begin
                            ones_all++;
                            if (k <= 100) ones100++;
                        end
                    end
                end
                if (finished) check_outputs(1'b0, 1'b1, 1'b0);
                else          check_outputs(1'b1, 1'b0, cur);
            end
            if (!finished) check("burst_timeout", 32'd0, 32'd1);
        end
        // A start coinciding with done_o must be dropped.
        bus.half_period_i = HW'(1);
        bus.duration_i    = DW'(1);
        bus.amplitude_i   = 8'd255;
        bus.repeat_i      = 2'd0;
        bus.start_i       = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        check_outputs(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outputs(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int o100, oall;
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.half_period_i = '0;
        bus.duration_i    = '0;
        bus.amplitude_i   = '0;
        bus.repeat_i      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_pwm", 32'(aud_pwm), 32'd0);
        check("rst_sd", 32'(aud_sd), 32'd0);
        rst = 1'b0;
        prev_busy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_outputs(1'b0, 1'b0, 1'b0);
        end

        // Single beep, 50% density in high phase.
        run_burst(2, 8, 128, 0, o100, oall);
        // Three beeps, two gaps, 25 ticks total.
        run_burst(2, 5, 200, 2, o100, oall);
        // Silence at zero amplitude.
        run_burst(2, 10, 0, 1, o100, oall);
        check("amp0_ones", 32'(oall), 32'd0);
        // Full scale: 99 ones in the first 100 ticks from a cleared accumulator.
        run_burst(100, 100, 255, 1, o100, oall);
        check("amp255_ones100", 32'(o100), 32'd99);
        // Degenerate requests.
        run_burst(3, 0, 100, 2, o100, oall);
        run_burst(0, 7, 100, 1, o100, oall);

        for (int i = 0; i < 10; i++) begin
            run_burst(int'($urandom_range(1, 6)), int'($urandom_range(1, 12)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), o100, oall);
            repeat (int'($urandom_range(0, 5))) begin
                @(negedge clk);
                check_outputs(1'b0, 1'b0, 1'b0);
            end
        end

        // Reset in the middle of a burst.
        @(negedge clk);
        bus.half_period_i = HW'(2);
        bus.duration_i    = DW'(50);
        bus.amplitude_i   = 8'd200;
        bus.repeat_i      = 2'd1;
        bus.start_i       = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (30) begin
            @(negedge clk);
            check("mid_busy", 32'(bus.busy_o), 32'd1);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", 32'(bus.busy_o), 32'd0);
            check("rst_done", 32'(bus.done_o), 32'd0);
            check("rst_pwm", 32'(aud_pwm), 32'd0);
            check("rst_sd", 32'(aud_sd), 32'd0);
        end
        rst = 1'b0;
        prev_busy = 1'b0;
        repeat (60) begin
            @(negedge clk);
            check_outputs(1'b0, 1'b0, 1'b0);
        end

        // Normal operation resumes after the abort.
        run_burst(1, 4, 128, 1, o100, oall);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
